mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller that sits directly downstream of the instruction fetch unit.
- Consumes the instruction word held in the instruction register (loaded from the fetch unit's insout) and the ALU zero flag.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives pc_wr, npc_sel, j_ctl and jr_ctl back to the fetch unit, plus datapath controls; also counts retired instructions.

Parameters:
- RESET_STATE, 4'd0, state code entered on reset (S_FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ins  in  32  instruction register output; stable from S_DCD until the next S_FETCH.
- zero  in  1  ALU zero flag, valid in S_BR.
- ir_wr  out  1  load instruction register with insout.
- pc_wr  out  1  PC write enable to fetch unit.
- npc_sel  out  1  non-sequential PC select.
- j_ctl  out  1  jump-target select (with npc_sel).
- jr_ctl  out  1  register-target select (with npc_sel).
- reg_wr  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALU result, 01 memory data, 10 pc+4.
- alu_src  out  1  0 = rt data, 1 = extended immediate.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 slt, 100 lui.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- mem_wr  out  1  data memory write enable.
- state  out  4  current state, for debug.
- icnt  out  32  retired-instruction counter.

Behaviour:
- States:
  - S_FETCH = 0
  - S_DCD = 1
  - S_EXE = 2
  - S_MA = 3
  - S_MR = 4
  - S_MW = 5
  - S_WB = 6
  - S_BR = 7
- State register updates on posedge clk. When reset = 0 at a clock edge: state ← S_FETCH and icnt ← 0. This applies mid-instruction too; the partial instruction is abandoned.
- Outputs are combinational from state and ins. zero affects only npc_sel, and only in S_BR.
- While reset = 0, all control outputs are forced to 0.
- Every control output not listed for a state is 0.
- Supported opcode/funct:
  - R-type (op 0x00): addu 0x21, subu 0x23, slt 0x2A, jr 0x08.
  - I-type: ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- S_FETCH: ir_wr = 1 → S_DCD.
- S_DCD:
  - j: pc_wr = npc_sel = j_ctl = 1 → S_FETCH.
  - jal: as j, plus reg_wr = 1, reg_dst = 10, mem_to_reg = 10 → S_FETCH.
  - jr: pc_wr = npc_sel = jr_ctl = 1 → S_FETCH.
  - R-type ALU, ori, lui → S_EXE.
  - lw, sw → S_MA.
  - beq → S_BR.
  - Undefined opcode/funct: pc_wr = 1, npc_sel = 0 (treated as nop) → S_FETCH.
- S_EXE → S_WB:
  - R-type: alu_src = 0; alu_op from funct (addu 000, subu 001, slt 011).
  - ori: alu_src = 1, ext_op = 00, alu_op = 010.
  - lui: alu_src = 1, ext_op = 10, alu_op = 100.
- S_MA: alu_src = 1, ext_op = 01, alu_op = 000. lw → S_MR; sw → S_MW.
- S_MR: address held (same ALU controls as S_MA) → S_WB.
- S_MW: mem_wr = 1, pc_wr = 1, address held → S_FETCH.
- S_WB: reg_wr = 1, pc_wr = 1 → S_FETCH.
  - reg_dst = 01 for R-type, 00 otherwise.
  - mem_to_reg = 01 for lw, 00 otherwise.
  - ALU controls held from S_EXE for non-lw.
- S_BR: alu_src = 0, alu_op = 001, pc_wr = 1, npc_sel = zero → S_FETCH.
- The branch offset is applied by the fetch unit to the un-updated pc+4; the PC changes only on pc_wr.
- Latency in cycles from S_FETCH:
  - j/jal/jr/undefined: 2
  - beq: 3
  - R/ori/lui/sw: 4
  - lw: 5
- icnt increments by 1 on every clock edge where pc_wr = 1 and reset = 1; it wraps 0xFFFFFFFF → 0.
- Illegal state codes (8–15) → S_FETCH on the next edge, with no outputs asserted.

Test Plan:
- Hold reset = 0 for 2 cycles, then release → state = 0, icnt = 0, all controls 0 during reset; ir_wr = 1 on the first cycle after release.
- ins = 0x00221821 (addu $3,$1,$2) → states 0,1,2,6,0. In S_WB: reg_wr = 1, reg_dst = 01, mem_to_reg = 00, pc_wr = 1. icnt = 1.
- ins = 0x8C430004 (lw) → states 0,1,3,4,6,0. In S_MA: ext_op = 01, alu_src = 1. In S_WB: mem_to_reg = 01, reg_dst = 00. 5 cycles total.
- ins = 0x10220003 (beq) run twice, with zero = 1 then zero = 0 in S_BR → npc_sel = 1 then 0; pc_wr = 1 both times; 3 cycles each.
- ins = 0x0C000C00 (jal) → in S_DCD: pc_wr = npc_sel = j_ctl = reg_wr = 1, reg_dst = 10, mem_to_reg = 10; next state 0. Then ins = 0x03E00008 (jr $31) → jr_ctl = 1, npc_sel = 1 in S_DCD.
- Assert reset = 0 during S_MR of a lw → next state 0, reg_wr never asserted, icnt = 0. Separately, ins = 0xFC000000 (undefined) → pc_wr = 1, npc_sel = 0, 2 cycles.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences each instruction through fetch, decode,
// execute, memory and writeback states and counts retired instructions.
module mc_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        npc_sel,
    output logic        j_ctl,
    output logic        jr_ctl,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        mem_wr,
    output logic [3:0]  state,
    output logic [31:0] icnt
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_EXE   = 4'd2,
        S_MA    = 4'd3,
        S_MR    = 4'd4,
        S_MW    = 4'd5,
        S_WB    = 4'd6,
        S_BR    = 4'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_JR    = 6'h08;

    logic [3:0]  state_r;
    logic [3:0]  next_s;
    logic [31:0] icnt_r;
    logic [5:0]  op_s;
    logic [5:0]  fn_s;
    logic        is_r_s, is_ralu_s, is_jr_s, is_ori_s, is_lui_s;
    logic        is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s;
    logic [5:0]  exe_alu_s;
    logic        unused_ins_s;

    // Execute-phase ALU controls packed as {alu_src, alu_op, ext_op}.
    function automatic logic [5:0] exe_alu(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] res;
        res = 6'b0;
        if (op == OP_ORI) begin
            res = {1'b1, 3'b010, 2'b00};
        end else if (op == OP_LUI) begin
            res = {1'b1, 3'b100, 2'b10};
        end else if (op == OP_RTYPE) begin
            case (fn)
                FN_ADDU: res = {1'b0, 3'b000, 2'b00};
                FN_SUBU: res = {1'b0, 3'b001, 2'b00};
                FN_SLT:  res = {1'b0, 3'b011, 2'b00};
                default: res = 6'b0;
            endcase
        end else begin
            res = 6'b0;
        end
        return res;
    endfunction

    assign op_s         = ins[31:26];
    assign fn_s         = ins[5:0];
    assign unused_ins_s = ^ins[25:6];
    assign is_r_s       = (op_s == OP_RTYPE);
    assign is_ralu_s    = is_r_s && ((fn_s == FN_ADDU) || (fn_s == FN_SUBU) || (fn_s == FN_SLT));
    assign is_jr_s      = is_r_s && (fn_s == FN_JR);
    assign is_ori_s     = (op_s == OP_ORI);
    assign is_lui_s     = (op_s == OP_LUI);
    assign is_lw_s      = (op_s == OP_LW);
    assign is_sw_s      = (op_s == OP_SW);
    assign is_beq_s     = (op_s == OP_BEQ);
    assign is_j_s       = (op_s == OP_J);
    assign is_jal_s     = (op_s == OP_JAL);
    assign exe_alu_s    = exe_alu(op_s, fn_s);

    // Next-state and control decode; everything is quiet while reset is low.
    always_comb begin
        next_s     = S_FETCH;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = 1'b0;
        j_ctl      = 1'b0;
        jr_ctl     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        ext_op     = 2'b00;
        mem_wr     = 1'b0;
        if (!reset) begin
            next_s = RESET_STATE;
        end else begin
            case (state_r)
                S_FETCH: begin
                    ir_wr  = 1'b1;
                    next_s = S_DCD;
                end
                S_DCD: begin
                    if (is_j_s || is_jal_s) begin
                        pc_wr   = 1'b1;
                        npc_sel = 1'b1;
                        j_ctl   = 1'b1;
                        if (is_jal_s) begin
                            reg_wr     = 1'b1;
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                        end else begin
                            reg_wr     = 1'b0;
                        end
                        next_s  = S_FETCH;
                    end else if (is_jr_s) begin
                        pc_wr   = 1'b1;
                        npc_sel = 1'b1;
                        jr_ctl  = 1'b1;
                        next_s  = S_FETCH;
                    end else if (is_ralu_s || is_ori_s || is_lui_s) begin
                        next_s = S_EXE;
                    end else if (is_lw_s || is_sw_s) begin
                        next_s = S_MA;
                    end else if (is_beq_s) begin
                        next_s = S_BR;
                    end else begin
                        pc_wr  = 1'b1;
                        next_s = S_FETCH;
                    end
                end
                S_EXE: begin
                    {alu_src, alu_op, ext_op} = exe_alu_s;
                    next_s = S_WB;
                end
                S_MA, S_MR: begin
                    alu_src = 1'b1;
                    ext_op  = 2'b01;
                    alu_op  = 3'b000;
                    if (state_r == S_MR) begin
                        next_s = S_WB;
                    end else if (is_lw_s) begin
                        next_s = S_MR;
                    end else if (is_sw_s) begin
                        next_s = S_MW;
                    end else begin
                        next_s = S_FETCH;
                    end
                end
                S_MW: begin
                    alu_src = 1'b1;
                    ext_op  = 2'b01;
                    mem_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    next_s  = S_FETCH;
                end
                S_WB: begin
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    reg_dst = is_r_s ? 2'b01 : 2'b00;
                    if (is_lw_s) begin
                        mem_to_reg = 2'b01;
                    end else begin
                        {alu_src, alu_op, ext_op} = exe_alu_s;
                    end
                    next_s = S_FETCH;
                end
                S_BR: begin
                    alu_op  = 3'b001;
                    pc_wr   = 1'b1;
                    npc_sel = zero;
                    next_s  = S_FETCH;
                end
                default: next_s = S_FETCH;
            endcase
        end
    end

    // State register and retired-instruction counter (one pc_wr per instruction).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RESET_STATE;
            icnt_r  <= 32'd0;
        end else begin
            state_r <= next_s;
            if (pc_wr) begin
                icnt_r <= icnt_r + 32'd1;
            end else begin
                icnt_r <= icnt_r;
            end
        end
    end

    assign state = state_r;
    assign icnt  = icnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed test-plan cases plus random
// instruction streams checked against a per-instruction-class reference model.
module tb_mc_ctrl;

    logic        clk, reset, zero;
    logic [31:0] ins;
    logic        ir_wr, pc_wr, npc_sel, j_ctl, jr_ctl, reg_wr, alu_src, mem_wr;
    logic [1:0]  reg_dst, mem_to_reg, ext_op;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] icnt;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic       npc_sel;
        logic       j_ctl;
        logic       jr_ctl;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       mem_wr;
    } ctl_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_LUI = 5;
    localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_UND = 11;

    ctl_t        dut_ctl;
    logic [3:0]  exp_st[$];
    ctl_t        exp_ctl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_icnt = 32'd0;

    assign dut_ctl = {ir_wr, pc_wr, npc_sel, j_ctl, jr_ctl, reg_wr, reg_dst,
                      mem_to_reg, alu_src, alu_op, ext_op, mem_wr};

    mc_ctrl dut (
        .clk(clk), .reset(reset), .ins(ins), .zero(zero),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .j_ctl(j_ctl),
        .jr_ctl(jr_ctl), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr),
        .state(state), .icnt(icnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (ins %h)", tag, got, exp, ins);
        end
    endtask

    function automatic int classify(input logic [31:0] i);
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h21:   return K_ADDU;
                6'h23:   return K_SUBU;
                6'h2A:   return K_SLT;
                6'h08:   return K_JR;
                default: return K_UND;
            endcase
        end
        case (op)
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_UND;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        int          k = $urandom_range(0, 11);
        logic [31:0] r = $urandom;
        logic [5:0]  bad_fn[4] = '{6'h20, 6'h22, 6'h00, 6'h3F};
        logic [5:0]  bad_op[4] = '{6'h01, 6'h05, 6'h08, 6'h3F};
        case (k)
            K_ADDU:  return {6'h00, r[25:6], 6'h21};
            K_SUBU:  return {6'h00, r[25:6], 6'h23};
            K_SLT:   return {6'h00, r[25:6], 6'h2A};
            K_JR:    return {6'h00, r[25:6], 6'h08};
            K_ORI:   return {6'h0D, r[25:0]};
            K_LUI:   return {6'h0F, r[25:0]};
            K_LW:    return {6'h23, r[25:0]};
            K_SW:    return {6'h2B, r[25:0]};
            K_BEQ:   return {6'h04, r[25:0]};
            K_J:     return {6'h02, r[25:0]};
            K_JAL:   return {6'h03, r[25:0]};
            default: return r[31] ? {6'h00, r[25:6], bad_fn[r[1:0]]} : {bad_op[r[1:0]], r[25:0]};
        endcase
    endfunction

    // Build the expected (state, controls) sequence for one instruction.
    task automatic build_expect(input logic [31:0] i);
        int   k = classify(i);
        ctl_t c;
        ctl_t alu;
        exp_st.delete();
        exp_ctl.delete();
        c = '0; c.ir_wr = 1'b1;
        exp_st.push_back(4'd0); exp_ctl.push_back(c);
        c = '0;
        case (k)
            K_J:   begin c.pc_wr = 1'b1; c.npc_sel = 1'b1; c.j_ctl = 1'b1; end
            K_JAL: begin c.pc_wr = 1'b1; c.npc_sel = 1'b1; c.j_ctl = 1'b1;
                         c.reg_wr = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
            K_JR:  begin c.pc_wr = 1'b1; c.npc_sel = 1'b1; c.jr_ctl = 1'b1; end
            K_UND: c.pc_wr = 1'b1;
            default: c = '0;
        endcase
        exp_st.push_back(4'd1); exp_ctl.push_back(c);
        alu = '0;
        case (k)
            K_SUBU: alu.alu_op = 3'b001;
            K_SLT:  alu.alu_op = 3'b011;
            K_ORI:  begin alu.alu_src = 1'b1; alu.alu_op = 3'b010; alu.ext_op = 2'b00; end
            K_LUI:  begin alu.alu_src = 1'b1; alu.alu_op = 3'b100; alu.ext_op = 2'b10; end
            K_LW, K_SW: begin alu.alu_src = 1'b1; alu.alu_op = 3'b000; alu.ext_op = 2'b01; end
            default: alu.alu_op = 3'b000;
        endcase
        if (k inside {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI}) begin
            exp_st.push_back(4'd2); exp_ctl.push_back(alu);
            c = alu; c.reg_wr = 1'b1; c.pc_wr = 1'b1;
            c.reg_dst = (k inside {K_ADDU, K_SUBU, K_SLT}) ? 2'b01 : 2'b00;
            exp_st.push_back(4'd6); exp_ctl.push_back(c);
        end else if (k == K_LW) begin
            exp_st.push_back(4'd3); exp_ctl.push_back(alu);
            exp_st.push_back(4'd4); exp_ctl.push_back(alu);
            c = '0; c.reg_wr = 1'b1; c.pc_wr = 1'b1; c.mem_to_reg = 2'b01;
            exp_st.push_back(4'd6); exp_ctl.push_back(c);
        end else if (k == K_SW) begin
            exp_st.push_back(4'd3); exp_ctl.push_back(alu);
            c = alu; c.mem_wr = 1'b1; c.pc_wr = 1'b1;
            exp_st.push_back(4'd5); exp_ctl.push_back(c);
        end else if (k == K_BEQ) begin
            c = '0; c.alu_op = 3'b001; c.pc_wr = 1'b1;
            exp_st.push_back(4'd7); exp_ctl.push_back(c);
        end
    endtask

    // Run one instruction from S_FETCH; zero is random each cycle and matters only in S_BR.
    task automatic run_instr(input logic [31:0] i, input int zsel);
        ctl_t c;
        ins = i;
        build_expect(i);
        for (int k = 0; k < exp_st.size(); k++) begin
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            @(negedge clk);
            c = exp_ctl[k];
            if (exp_st[k] == 4'd7) c.npc_sel = zero;
            check($sformatf("state[%0d]", k), {28'd0, state}, {28'd0, exp_st[k]});
            check($sformatf("ctl[%0d]", k), {15'd0, dut_ctl}, {15'd0, c});
            @(posedge clk);
            #1;
        end
        model_icnt = model_icnt + 32'd1;
        check("return_to_fetch", {28'd0, state}, 32'd0);
        check("icnt", icnt, model_icnt);
    endtask

    initial begin
        reset = 1'b0;
        ins   = 32'd0;
        zero  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ctl", {15'd0, dut_ctl}, 32'd0);
        check("rst_state", {28'd0, state}, 32'd0);
        @(posedge clk); #1;
        check("rst_icnt", icnt, 32'd0);
        check("rst_ctl2", {15'd0, dut_ctl}, 32'd0);
        reset = 1'b1;

        run_instr(32'h00221821, -1);
        run_instr(32'h8C430004, -1);
        run_instr(32'h10220003, 1);
        run_instr(32'h10220003, 0);
        run_instr(32'h0C000C00, -1);
        run_instr(32'h03E00008, -1);
        run_instr(32'hFC000000, -1);

        for (int n = 0; n < 300; n++) begin
            run_instr(rand_ins(), -1);
        end

        // Abandon a lw in S_MR: no writeback, counter cleared.
        ins = 32'h8C430004;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        check("mr_state", {28'd0, state}, 32'd4);
        reset = 1'b0;
        @(negedge clk);
        check("mr_rst_ctl", {15'd0, dut_ctl}, 32'd0);
        check("mr_rst_regwr", {31'd0, reg_wr}, 32'd0);
        @(posedge clk); #1;
        check("mr_rst_state", {28'd0, state}, 32'd0);
        check("mr_rst_icnt", icnt, 32'd0);
        reset = 1'b1;
        model_icnt = 32'd0;
        run_instr(32'h00221821, -1);
        for (int n = 0; n < 20; n++) begin
            run_instr(rand_ins(), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
